freq_gen: RTL

Programmable square-wave generator that drives one IO. It is the transmit-side counterpart of the frequency measurement block. Software loads a period, a high time and a pulse count, then pulses start. The block emits that many pulses, or runs continuously until stopped, and reports completion with a sticky done flag. It sits on the same command path as the measurement block, so a generated IO can be looped back and measured.

---
 rtl/freq_gen_if.sv | 24 ++
 rtl/freq_gen.sv | 66 ++++++
 2 files changed

// File: rtl/freq_gen_if.sv
// freq_gen_if: command and status signals of the square-wave generator
interface freq_gen_if #(
  parameter int FREQ_DATA_NBIT = 32,
  parameter int FREQ_CNT_NBIT  = 16
);
  logic                      start;
  logic                      stop;
  logic [FREQ_DATA_NBIT-1:0] i_period;
  logic [FREQ_DATA_NBIT-1:0] i_high;
  logic [FREQ_CNT_NBIT-1:0]  i_cnt;
  logic                      o_io;
  logic [FREQ_CNT_NBIT-1:0]  o_cnt;
  logic                      o_busy;
  logic                      o_err;
  logic                      done;
  modport master (
    output start, stop, i_period, i_high, i_cnt,
    input  o_io, o_cnt, o_busy, o_err, done
  );
  modport slave (
    input  start, stop, i_period, i_high, i_cnt,
    output o_io, o_cnt, o_busy, o_err, done
  );
endinterface

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator with pulse count and sticky done
module freq_gen #(
  parameter int FREQ_DATA_NBIT = 32,
  parameter int FREQ_CNT_NBIT  = 16
) (
  input logic       clk,
  input logic       rst_n,
  freq_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t                    state;
  logic [FREQ_DATA_NBIT-1:0] per, hi, phase, np;
  logic [FREQ_CNT_NBIT-1:0]  n, cnt_nx;
  logic                      wrap, last, bad;
  // phase stepping, period-end detection and start-config validity
  always_comb begin
    wrap   = phase == per - FREQ_DATA_NBIT'(1);
    np     = wrap ? '0 : phase + FREQ_DATA_NBIT'(1);
    cnt_nx = bus.o_cnt + FREQ_CNT_NBIT'(1);
    last   = wrap && n != '0 && cnt_nx == n;
    bad    = bus.i_period < FREQ_DATA_NBIT'(2) || bus.i_high == '0 || bus.i_high >= bus.i_period;
  end
  // control FSM; a period that ends on the stop edge still counts as completed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      per        <= '0;
      hi         <= '0;
      n          <= '0;
      phase      <= '0;
      bus.o_io   <= 1'b0;
      bus.o_cnt  <= '0;
      bus.o_busy <= 1'b0;
      bus.o_err  <= 1'b0;
      bus.done   <= 1'b0;
    end else if (bus.start) begin
      per        <= bus.i_period;
      hi         <= bus.i_high;
      n          <= bus.i_cnt;
      phase      <= '0;
      bus.o_cnt  <= '0;
      bus.o_io   <= !bad;
      bus.o_busy <= !bad;
      bus.o_err  <= bad;
      bus.done   <= bad;
      state      <= bad ? FINISH : RUN;
    end else begin
      case (state)
        RUN: begin
          bus.o_cnt <= wrap ? cnt_nx : bus.o_cnt;
          if (bus.stop || last) begin
            bus.o_io   <= 1'b0;
            bus.o_busy <= 1'b0;
            bus.done   <= 1'b1;
            state      <= FINISH;
          end else begin
            phase    <= np;
            bus.o_io <= np < hi;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
